// File: rtl/dm_responder_if.sv
// dm_responder_if -- request/response bundle between the M-stage memory
// port of the pipelined MIPS core (master) and the data-memory responder
// (slave).
//
// Signals:
//   req_valid    master->slave  request present
//   req_ready    slave->master  responder can accept this cycle
//   req_addr     master->slave  byte address
//   req_st_type  master->slave  0 load, 1 sw, 2 sh, 3 sb
//   req_ld_type  master->slave  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh (5..7 = lw)
//   req_wdata    master->slave  store data
//   req_pc       master->slave  PC of issuing instruction (logging only)
//   resp_valid   slave->master  one-cycle response strobe
//   resp_rdata   slave->master  extended load data (0 for stores/errors)
//   resp_err     slave->master  misaligned-access flag
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_st_type;
  logic [2:0]  req_ld_type;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_st_type, req_ld_type, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_st_type, req_ld_type, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder -- data-memory responder behind the M-stage memory port.
// Accepts one load/store at a time, waits LATENCY cycles, then issues a
// one-cycle response. Little-endian byte lanes; misaligned accesses are
// reported through resp_err and never touch memory.
//
// Parameters:
//   ADDR_W   word-index width (2^ADDR_W 32-bit words)
//   LATENCY  wait cycles between accept and response (0..15)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (clears state and whole memory)
//   bus    dm_responder_if.slave request/response bundle
//
// Optional build macro:
//   DM_LOG_EN  when defined, every committed aligned store prints
//              "<time>@<pc>: *<word address> <= <merged word>".
module dm_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [1:0]  st_q;
  logic [2:0]  ld_q;
  logic        err_q;

  logic [31:0] mem_q [2**ADDR_W];

  logic        accept;
  logic        misalign;
  logic        ready;
  logic        resp;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          state_d = (LATENCY > 0) ? WAIT : RESP;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept = ready & bus.req_valid;

  // Alignment is judged against the access size implied by the types.
  always_comb begin
    misalign = 1'b0;
    case (bus.req_st_type)
      2'd1: misalign = (bus.req_addr[1:0] != 2'b00);
      2'd2: misalign = bus.req_addr[0];
      2'd3: misalign = 1'b0;
      default: begin
        case (bus.req_ld_type)
          3'd1, 3'd2: misalign = 1'b0;
          3'd3, 3'd4: misalign = bus.req_addr[0];
          default:    misalign = (bus.req_addr[1:0] != 2'b00);
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      st_q    <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      pc_q    <= bus.req_pc;
      st_q    <= bus.req_st_type;
      ld_q    <= bus.req_ld_type;
      err_q   <= misalign;
    end
  end

  // ----------------------------------------------------------- datapath
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [31:0]       wrep;
  logic [3:0]        be;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic              commit;

  assign word_idx = addr_q[ADDR_W+1:2];
  assign rd_word  = mem_q[word_idx];

  // Replicate narrow store data onto every lane; the byte enables pick.
  always_comb begin
    wrep = wdata_q;
    be   = 4'b0000;
    case (st_q)
      2'd1: begin wrep = wdata_q;             be = 4'b1111; end
      2'd2: begin wrep = {2{wdata_q[15:0]}};  be = addr_q[1] ? 4'b1100 : 4'b0011; end
      2'd3: begin wrep = {4{wdata_q[7:0]}};   be = 4'b0001 << addr_q[1:0]; end
      default: begin wrep = wdata_q;          be = 4'b0000; end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = be[gi] ? wrep[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = 8'(rd_word >> {addr_q[1:0], 3'b000});
  assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (ld_q)
      3'd1:    load_data = {24'd0, byte_sel};
      3'd2:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd3:    load_data = {16'd0, half_sel};
      3'd4:    load_data = {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Stores land on the edge that closes the RESP cycle.
  assign commit = resp & (st_q != 2'd0) & ~err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[word_idx] <= merged;
    end
  end

`ifdef DM_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && commit)
      $display("%0t@%08h: *%08h <= %08h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
  end
`endif

  // Bits that only matter for the optional store log.
  logic unused_bits;
  assign unused_bits = ^{pc_q, addr_q[31:ADDR_W+2]};

  // ------------------------------------------------------------ outputs
  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp;
  assign bus.resp_err   = resp & err_q;
  assign bus.resp_rdata = (resp && st_q == 2'd0 && !err_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_responder_if if2();
  dm_responder_if if0();

  dm_responder #(.ADDR_W(12), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  dm_responder #(.ADDR_W(12), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memories: one per DUT, indexed by word.
  logic [31:0] mdl2 [4096];
  logic [31:0] mdl0 [4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic get_rv(input int sel);
    return (sel == 2) ? if2.resp_valid : if0.resp_valid;
  endfunction
  function automatic logic get_ready(input int sel);
    return (sel == 2) ? if2.req_ready : if0.req_ready;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 2) ? if2.resp_rdata : if0.resp_rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 2) ? if2.resp_err : if0.resp_err;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 4096; i++) begin
      mdl2[i] = '0;
      mdl0[i] = '0;
    end
  endtask

  // Behavioural model: access size, alignment by modulo, byte-wise merge,
  // shift/mask extraction and arithmetic sign extension.
  task automatic model_op(input int sel, input logic [31:0] addr, input logic [1:0] st,
                          input logic [2:0] ld, input logic [31:0] wd,
                          output logic [31:0] er, output logic ee);
    int size, off, idx;
    logic [31:0] word;
    longint unsigned v, span;
    if (st == 2'd1)                    size = 4;
    else if (st == 2'd2)               size = 2;
    else if (st == 2'd3)               size = 1;
    else if (ld == 3'd1 || ld == 3'd2) size = 1;
    else if (ld == 3'd3 || ld == 3'd4) size = 2;
    else                               size = 4;
    off  = int'(addr % 4);
    idx  = int'((addr / 4) % 4096);
    word = (sel == 2) ? mdl2[idx] : mdl0[idx];
    er   = '0;
    ee   = (addr % size) != 0;
    if (ee) return;
    if (st != 2'd0) begin
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      if (sel == 2) mdl2[idx] = word;
      else          mdl0[idx] = word;
    end else begin
      span = 64'd1 << (8 * size);
      v    = (64'(word) >> (8 * off)) % span;
      if ((ld == 3'd2 || ld == 3'd4) && v >= span / 2) v = v - span;
      er = v[31:0];
    end
  endtask

  task automatic drive(input int sel, input logic valid, input logic [31:0] addr,
                       input logic [1:0] st, input logic [2:0] ld, input logic [31:0] wd);
    logic [31:0] pc;
    pc = 32'h0040_0000 + {$urandom_range(0, 255), 2'b00};
    if2.req_addr = addr; if2.req_st_type = st; if2.req_ld_type = ld;
    if2.req_wdata = wd; if2.req_pc = pc;
    if0.req_addr = addr; if0.req_st_type = st; if0.req_ld_type = ld;
    if0.req_wdata = wd; if0.req_pc = pc;
    if2.req_valid = (sel == 2) ? valid : 1'b0;
    if0.req_valid = (sel == 0) ? valid : 1'b0;
  endtask

  // One full transaction on the selected DUT, checked against the model.
  task automatic do_req(input int sel, input logic [31:0] addr, input logic [1:0] st,
                        input logic [2:0] ld, input logic [31:0] wd,
                        output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] er;
    logic        ee;
    int          lat, cyc;
    logic        seen;
    lat = (sel == 2) ? 2 : 0;
    model_op(sel, addr, st, ld, wd, er, ee);
    @(negedge clk);
    drive(sel, 1'b1, addr, st, ld, wd);
    check("ready_idle", 32'(get_ready(sel)), 32'd1);
    @(negedge clk);
    drive(sel, 1'b0, 32'hFFFF_FFFF, 2'd1, 3'd0, 32'hFFFF_FFFF);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (get_rv(sel)) seen = 1'b1;
      else begin
        check("ready_busy", 32'(get_ready(sel)), 32'd0);
        check("rdata_quiet", get_rdata(sel), 32'd0);
        cyc++;
        @(negedge clk);
      end
    end
    check("resp_latency", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat + 1));
    got_rdata = get_rdata(sel);
    got_err   = get_err(sel);
    check("resp_rdata", got_rdata, er);
    check("resp_err", 32'(got_err), 32'(ee));
    check("ready_in_resp", 32'(get_ready(sel)), 32'd0);
    $display("[TB] L%0d st=%0d ld=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
             lat, st, ld, addr, wd, got_rdata, got_err, cyc);
    @(negedge clk);
    check("resp_one_cycle", 32'(get_rv(sel)), 32'd0);
    check("ready_back", 32'(get_ready(sel)), 32'd1);
  endtask

  // Hold a load request continuously and count response strobes.
  task automatic burst(input int sel, input int ncyc, input int exp_pulses);
    int pulses;
    pulses = 0;
    @(negedge clk);
    drive(sel, 1'b1, 32'h0000_0010, 2'd0, 3'd0, 32'd0);
    repeat (ncyc) begin
      @(negedge clk);
      if (get_rv(sel)) pulses++;
    end
    drive(sel, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);
    $display("[TB] burst L%0d cycles=%0d pulses=%0d", (sel == 2) ? 2 : 0, ncyc, pulses);
    check("burst_pulses", 32'(pulses), 32'(exp_pulses));
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er_o;

  initial begin
    clear_models();
    reset = 1'b1;
    drive(2, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);
    repeat (3) @(negedge clk);
    for (int s = 0; s <= 2; s += 2) begin
      check("reset_ready", 32'(get_ready(s)), 32'd1);
      check("reset_rv", 32'(get_rv(s)), 32'd0);
      check("reset_rdata", get_rdata(s), 32'd0);
      check("reset_err", 32'(get_err(s)), 32'd0);
    end
    reset = 1'b0;

    // Directed sequence on the LATENCY=2 instance.
    do_req(2, 32'h40, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_lw_zero", rd, 32'h0);
    do_req(2, 32'h10, 2'd1, 3'd0, 32'h1234_5678, rd, er_o);
    do_req(2, 32'h10, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_lw", rd, 32'h1234_5678);
    do_req(2, 32'h13, 2'd3, 3'd0, 32'h0000_00AB, rd, er_o);
    do_req(2, 32'h10, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_sb_word", rd, 32'hAB34_5678);
    do_req(2, 32'h13, 2'd0, 3'd2, 32'd0, rd, er_o);        check("plan_lb", rd, 32'hFFFF_FFAB);
    do_req(2, 32'h13, 2'd0, 3'd1, 32'd0, rd, er_o);        check("plan_lbu", rd, 32'h0000_00AB);
    do_req(2, 32'h10, 2'd2, 3'd0, 32'h0000_8001, rd, er_o);
    do_req(2, 32'h10, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_sh_word", rd, 32'hAB34_8001);
    do_req(2, 32'h10, 2'd0, 3'd4, 32'd0, rd, er_o);        check("plan_lh", rd, 32'hFFFF_8001);
    do_req(2, 32'h10, 2'd0, 3'd3, 32'd0, rd, er_o);        check("plan_lhu", rd, 32'h0000_8001);
    do_req(2, 32'h12, 2'd1, 3'd0, 32'h5555_5555, rd, er_o); check("plan_sw_mis", 32'(er_o), 32'd1);
    do_req(2, 32'h11, 2'd0, 3'd4, 32'd0, rd, er_o);        check("plan_lh_mis", 32'(er_o), 32'd1);
    check("plan_lh_mis_data", rd, 32'd0);
    do_req(2, 32'h10, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_unchanged", rd, 32'hAB34_8001);
    burst(2, 12, 3);

    // Reset during WAIT of a store: no response, nothing written.
    @(negedge clk);
    drive(2, 1'b1, 32'h20, 2'd1, 3'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(2, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_models();
    check("midreset_ready", 32'(if2.req_ready), 32'd1);
    begin
      int pulses;
      pulses = 0;
      repeat (6) begin
        if (if2.resp_valid) pulses++;
        @(negedge clk);
      end
      $display("[TB] reset during WAIT, strobes afterwards=%0d", pulses);
      check("midreset_no_resp", 32'(pulses), 32'd0);
    end
    do_req(2, 32'h20, 2'd0, 3'd0, 32'd0, rd, er_o);        check("plan_reset_lw", rd, 32'h0);

    // LATENCY=0 instance: throughput and address aliasing.
    burst(0, 8, 4);
    do_req(0, 32'h0000_4010, 2'd1, 3'd0, 32'hCAFE_F00D, rd, er_o);
    do_req(0, 32'h0000_0010, 2'd0, 3'd0, 32'd0, rd, er_o); check("plan_alias", rd, 32'hCAFE_F00D);

    // Randomized traffic on both instances inside a small window so loads
    // frequently hit earlier stores; high address bits exercise wrapping.
    for (int s = 0; s <= 2; s += 2) begin
      for (int n = 0; n < 80; n++) begin
        logic [31:0] a;
        logic [1:0]  st;
        logic [2:0]  ld;
        a = 32'h100 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        if ($urandom_range(0, 3) == 0) a[31:14] = 18'($urandom);
        st = 2'($urandom_range(0, 3));
        ld = 3'($urandom_range(0, 7));
        do_req(s, a, st, ld, $urandom, rd, er_o);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the far end of the M-stage memory interface of the pipelined MIPS core.
- Accepts one load or store request at a time through a valid/ready handshake, waits a configurable number of cycles, then returns a one-cycle response.
- Store width follows the M-stage store type (word/half/byte). Load extension follows the M-stage load type.
- Little-endian byte lanes. Misaligned accesses are flagged, not executed.

Parameters:
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W 32-bit words (default 16 KB).
- LATENCY, 2, wait cycles inserted between accept and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address.
- req_st_type  input  2  store type: 0 = no store (load), 1 = sw, 2 = sh, 3 = sb.
- req_ld_type  input  3  load type, used only when req_st_type = 0: 0 = lw, 1 = lbu, 2 = lb, 3 = lhu, 4 = lh. Values 5..7 behave as lw.
- req_wdata  input  32  store data; sh uses bits 15:0, sb uses bits 7:0.
- req_pc  input  32  PC of the issuing instruction; used only for logging.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned-access flag, qualified by resp_valid.

Behaviour:
- Reset:
  - State goes to IDLE. Wait counter clears. All memory words clear to 0.
  - Outputs during and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Reset asserted mid-transaction drops the pending request. No write commits from a request still in WAIT. No response is issued.
- States:
  - IDLE: req_ready=1. Accept on req_valid & req_ready. Latch addr, types, wdata and pc. Go to WAIT if LATENCY>0, else RESP.
  - WAIT: req_ready=0. Counter loads LATENCY-1 on accept and decrements each cycle. At 0, go to RESP.
  - RESP: req_ready=0. resp_valid=1 for exactly one cycle. Next state is IDLE.
- Latency: resp_valid rises LATENCY+1 cycles after the accept edge. Back-to-back throughput is one request per LATENCY+2 cycles.
- Word index: latched addr[ADDR_W+1:2]. Higher address bits are ignored, so out-of-range addresses wrap.
- Alignment check at accept:
  - sw, lw: addr[1:0] must be 0.
  - sh, lh, lhu: addr[0] must be 0.
  - Byte accesses are always aligned.
  - A misaligned access writes nothing and returns resp_err=1, resp_rdata=0.
- Stores:
  - Commit on the edge that leaves WAIT/RESP toward IDLE, i.e. in the RESP cycle.
  - sw writes the full word.
  - sh writes lane pair addr[1] (0 → bits 15:0, 1 → bits 31:16).
  - sb writes lane addr[1:0] (0 → bits 7:0 … 3 → bits 31:24).
  - Unwritten lanes are preserved.
- Loads:
  - resp_rdata is read combinationally from the array during RESP, so a load issued after a store sees the stored data.
  - Byte/half selected by address, then zero-extended (lbu, lhu) or sign-extended (lb, lh).
- Request inputs are ignored while req_ready=0. resp_rdata and resp_err hold 0 whenever resp_valid=0.

Optional Feature:
- Macro: DM_LOG_EN.
- Defined: on every committed, aligned store, simulation prints "$time@pc: *addr <= data". Here addr is the word-aligned byte address and data is the full resulting 32-bit word after merge.
- Undefined: no display statements are compiled. Functional behaviour is identical.

Test Plan:
- Reset with LATENCY=2 → req_ready=1, resp_valid=0; a lw at 0x0000_0040 returns resp_rdata=0x0000_0000.
- sw 0x1234_5678 @0x10, then lw @0x10 → resp_valid exactly 3 cycles after each accept; rdata=0x1234_5678; req_ready low for 3 cycles per request.
- After word 0x10 = 0x1234_5678: sb 0xAB @0x13 → word 0xAB34_5678. lb @0x13 → 0xFFFF_FFAB. lbu → 0x0000_00AB. sh 0x8001 @0x10 → word 0xAB34_8001. lh @0x10 → 0xFFFF_8001. lhu → 0x0000_8001.
- sw @0x12 and lh @0x11 → resp_err=1, rdata=0; memory at 0x10 unchanged.
- Reset asserted during WAIT of a sw 0xDEAD_BEEF @0x20 → no resp_valid; lw @0x20 after reset returns 0.
- LATENCY=0 build: back-to-back requests → resp_valid on the cycle after each accept; accepts every 2 cycles. Address 0x0000_4010 (ADDR_W=12) aliases 0x10.
